// File: rtl/cap_frame_writer.sv
// cap_frame_writer: AXI4 write master that drains the camera pixel FIFO and
// stores each frame in DRAM as 32-bit XRGB pixels, using fixed 8-beat 64-bit
// bursts. A burst is started only after the FIFO reports a full burst of data.
module cap_frame_writer #(
  parameter int BURSTS_PER_FRAME = 19200
) (
  input  logic        ACLK,
  input  logic        ARST,
  // control / status towards the register block
  input  logic        START,
  input  logic [31:0] BASEADDR,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  // capture FIFO read port
  output logic        FIFORD,
  input  logic        FIFOVALID,
  input  logic        HASDATA,
  input  logic [47:0] READDATA,
  // AXI write address channel
  output logic [31:0] AWADDR,
  output logic [7:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,
  // AXI write data channel
  output logic [63:0] WDATA,
  output logic [7:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  // AXI write response channel
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  localparam int CNT_W = $clog2(BURSTS_PER_FRAME + 1);
  localparam logic [CNT_W-1:0] LAST_BURST = CNT_W'(BURSTS_PER_FRAME - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] burst_cnt;
  logic [3:0]       rd_cnt;      // FIFO reads issued in this burst (0..8)
  logic [3:0]       cap_cnt;     // FIFO words captured in this burst (0..8)
  logic             aw_done;     // address phase of this burst accepted
  logic [2:0]       beat;        // index of the beat currently on WDATA
  logic [47:0]      pix_buf [8];

  logic capture;
  logic fill_done;
  logic aw_ok;

  // Burst shape is fixed: 8 beats of 8 bytes, incrementing, all lanes written.
  assign AWLEN   = 8'd7;
  assign AWSIZE  = 3'b011;
  assign AWBURST = 2'b01;
  assign WSTRB   = 8'hFF;

  // The low address bits are forced to zero so every burst is 64-byte aligned.
  logic unused_baseaddr_lsbs;
  assign unused_baseaddr_lsbs = ^BASEADDR[5:0];

  // Pack two 24-bit pixels as XRGB words, pixel0 in the low (lower-address) half.
  function automatic logic [63:0] to_xrgb(input logic [47:0] word);
    return {8'h00, word[47:24], 8'h00, word[23:0]};
  endfunction

  // Only FIFO data answering one of our own reads is taken; strays are dropped.
  assign capture   = (state == S_FILL) && FIFOVALID && (cap_cnt < rd_cnt);
  // Look ahead at the 8th capture / AW handshake so DATA starts without a bubble.
  assign fill_done = (cap_cnt == 4'd8) || (capture && (cap_cnt == 4'd7));
  assign aw_ok     = aw_done || (AWVALID && AWREADY);

  // Burst buffer write: FIFO word n lands in entry n.
  // NOTE: pure data storage is never read before being written, so it has no reset.
  always_ff @(posedge ACLK) begin
    if (capture) pix_buf[cap_cnt[2:0]] <= READDATA;
  end

  // Main control FSM with all registered outputs.
  // NOTE: state is updated with <= so every branch sees the pre-edge values.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      state     <= S_IDLE;
      burst_cnt <= '0;
      rd_cnt    <= '0;
      cap_cnt   <= '0;
      aw_done   <= 1'b0;
      beat      <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      FIFORD    <= 1'b0;
      AWADDR    <= '0;
      AWVALID   <= 1'b0;
      WDATA     <= '0;
      WLAST     <= 1'b0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            AWADDR    <= {BASEADDR[31:6], 6'b0};
            AWVALID   <= 1'b1;
            burst_cnt <= '0;
            rd_cnt    <= '0;
            cap_cnt   <= '0;
            aw_done   <= 1'b0;
            ERR       <= 1'b0;
            BUSY      <= 1'b1;
            state     <= S_FILL;
          end
        end

        S_FILL: begin
          // Once started, the 8 reads run back to back; HASDATA already
          // guaranteed the FIFO holds them.
          if (FIFORD) rd_cnt <= rd_cnt + 4'd1;
          FIFORD <= FIFORD ? (rd_cnt != 4'd7) : ((rd_cnt == 4'd0) && HASDATA);
          if (capture) cap_cnt <= cap_cnt + 4'd1;
          if (AWVALID && AWREADY) begin
            AWVALID <= 1'b0;
            aw_done <= 1'b1;
          end
          if (fill_done && aw_ok) begin
            WVALID <= 1'b1;
            WDATA  <= to_xrgb(pix_buf[0]);
            WLAST  <= 1'b0;
            beat   <= '0;
            state  <= S_DATA;
          end
        end

        S_DATA: begin
          // WDATA/WLAST only move on a completed beat, so they are stable while stalled.
          if (WVALID && WREADY) begin
            if (beat == 3'd7) begin
              WVALID <= 1'b0;
              WLAST  <= 1'b0;
              BREADY <= 1'b1;
              state  <= S_RESP;
            end else begin
              beat  <= beat + 3'd1;
              WDATA <= to_xrgb(pix_buf[beat + 3'd1]);
              WLAST <= (beat == 3'd6);
            end
          end
        end

        S_RESP: begin
          if (BVALID && BREADY) begin
            BREADY    <= 1'b0;
            AWADDR    <= AWADDR + 32'd64;
            burst_cnt <= burst_cnt + 1'b1;
            if (BRESP != 2'b00) ERR <= 1'b1;
            if (burst_cnt == LAST_BURST) begin
              DONE  <= 1'b1;
              BUSY  <= 1'b0;
              state <= S_IDLE;
            end else begin
              AWVALID <= 1'b1;
              rd_cnt  <= '0;
              cap_cnt <= '0;
              aw_done <= 1'b0;
              state   <= S_FILL;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cap_frame_writer.md
# cap_frame_writer

AXI4 write master that drains the camera pixel FIFO (ACLK read side) and stores each captured frame into DRAM as 32-bit XRGB pixels. It sits between the capture FIFO's read port (FIFORD/FIFOVALID/HASDATA/READDATA) and the memory interconnect's AXI write channels. It issues fixed 8-beat, 64-bit bursts only when the FIFO reports at least 8 words. It reports frame completion and write errors to the register block.

## Interface
- BURSTS_PER_FRAME, 19200, bursts per frame (default 640x480 px / 2 px per word / 8 words per burst)
- ACLK  in  1  system clock; all logic on rising edge
- ARST  in  1  asynchronous reset, active-high
- START  in  1  one-cycle pulse; begins a frame when idle
- BASEADDR  in  32  frame base byte address; bits [5:0] ignored (treated as 0); sampled on accepted START
- BUSY  out  1  high from accepted START until DONE
- DONE  out  1  one-cycle pulse after last B response of frame
- ERR  out  1  sticky; set on any BRESP != 2'b00, cleared by accepted START
- FIFORD  out  1  FIFO read enable
- FIFOVALID  in  1  READDATA valid, one cycle after FIFORD
- HASDATA  in  1  FIFO holds >= 8 words
- READDATA  in  48  {pixel1[23:0], pixel0[23:0]}
- AWADDR  out  32; AWLEN out 8 (const 8'd7); AWSIZE out 3 (const 3'b011); AWBURST out 2 (const 2'b01); AWVALID out 1; AWREADY in 1
- WDATA  out  64; WSTRB out 8 (const 8'hFF); WLAST out 1; WVALID out 1; WREADY in 1
- BRESP  in  2; BVALID in 1; BREADY out 1

## Operation
- States: IDLE, FILL, DATA, RESP.
- IDLE: accepted START (START=1 in IDLE) latches {BASEADDR[31:6],6'b0} into address register, clears burst counter and ERR, sets BUSY, goes to FILL. START outside IDLE is ignored.
- FILL: waits for HASDATA=1, then asserts FIFORD for exactly 8 consecutive cycles (HASDATA not re-checked). Each FIFOVALID stores READDATA into local buffer entry 0..7 in order. Concurrently, AWVALID asserts on FILL entry with AWADDR = current address and holds until AWREADY. Leave FILL when all 8 entries captured AND AW handshake done.
- DATA: WVALID=1, WDATA = {8'h00, buf[i][47:24], 8'h00, buf[i][23:0]}, i=0..7; i advances on WVALID&WREADY; WLAST=1 when i=7. After beat 7 handshake -> RESP.
- RESP: BREADY=1; on BVALID: ERR |= (BRESP!=0); address += 64; burst counter += 1. If counter reaches BURSTS_PER_FRAME -> pulse DONE, clear BUSY, IDLE; else FILL.
- FIFOVALID outside an expected capture is ignored. WDATA pixel order: pixel0 at lower address.
- Address wraps modulo 2^32; 64-byte aligned bursts never cross 4 KB.
- Counter width: clog2(BURSTS_PER_FRAME+1).

## Timing
- Reset values: FIFORD, AWVALID, WVALID, WLAST, BREADY, BUSY, DONE, ERR = 0; AWADDR = 0; state IDLE; counters 0.
- Accepted START -> AWVALID=1 and BUSY=1 next cycle.
- HASDATA high on FILL entry -> FIFORD high same-state next edge for 8 cycles; 8th FIFOVALID one cycle after last FIFORD.
- Minimum burst period with zero-wait AXI: 1 (FILL entry) + 8 (reads) + 1 (last valid) + 8 (beats) + 1 (B) = 19 cycles.
- WVALID, once asserted, stays high and WDATA/WLAST stable until WREADY.
- AWVALID stays high with AWADDR stable until AWREADY.
- Outputs are registered; no combinational path from AXI ready/valid inputs to outputs.
- ARST mid-frame: immediate return to reset values; partial burst abandoned; FIFO contents are the owner's concern (FIFORST).

## Test plan
- Single frame, BURSTS_PER_FRAME=2, BASEADDR=32'h1000_0023, ready signals tied 1, HASDATA=1 -> bursts at 32'h1000_0000 and 32'h1000_0040, AWLEN=7, DONE pulses once, BUSY falls with DONE.
- READDATA = 48'hAABBCC_112233 in beat 0 -> WDATA = 64'h00AABBCC_00112233, WSTRB=FF, WLAST only on beat 7.
- HASDATA=0 for 50 cycles after START -> FIFORD stays 0, AWVALID high awaiting AWREADY; HASDATA=1 -> exactly 8 FIFORD cycles.
- WREADY random 50% and AWREADY delayed 10 cycles -> data order and WDATA stability preserved, no extra FIFORD.
- BRESP=2'b10 on first of 3 bursts -> ERR=1 through DONE; next START clears ERR.
- START pulse while BUSY -> ignored, burst count unchanged; ARST asserted during DATA -> all outputs 0 next cycle, BUSY=0.
